// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Brief    : Shared FSM state encoding and forwarding-select constants for
//            the pipeline hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } hazard_state_e;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_if
// Brief    : Pipeline-to-hazard-controller signal bundle. The pipeline is the
//            master (drives register ids / memory status), the controller is
//            the slave (drives stalls, flushes, forwards and status).
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic [4:0]           Rs1D, Rs2D;
    logic [4:0]           Rs1E, Rs2E, RdE;
    logic [1:0]           ResultSrcE;
    logic                 PCSrcE;
    logic [4:0]           RdM, RdW;
    logic                 RegWriteM, RegWriteW;
    logic                 mem_req, mem_ready;
    logic                 StallF, StallD, StallE, StallM;
    logic                 FlushD, FlushE, FlushW;
    logic [1:0]           ForwardAE, ForwardBE;
    logic                 mem_err;
    logic [CNT_WIDTH-1:0] stall_cycles;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
        output RdM, RdW, RegWriteM, RegWriteW, mem_req, mem_ready,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        input  ForwardAE, ForwardBE, mem_err, stall_cycles
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
        input  RdM, RdW, RegWriteM, RegWriteW, mem_req, mem_ready,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        output ForwardAE, ForwardBE, mem_err, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/forward_unit.sv
`default_nettype none
// ============================================================================
// Module   : forward_unit
// Brief    : Single-operand forwarding select; Memory stage beats Writeback.
// Revision : 1.0 - initial release
// ============================================================================
module forward_unit
    import hazard_pkg::*;
(
    input  wire logic [4:0] i_rs,
    input  wire logic [4:0] i_rd_m,
    input  wire logic [4:0] i_rd_w,
    input  wire logic       i_reg_write_m,
    input  wire logic       i_reg_write_w,
    output logic [1:0]      o_fwd
);

    always_comb begin
        o_fwd = FWD_NONE;
        if (i_reg_write_m && (i_rd_m != 5'd0) && (i_rd_m == i_rs)) begin
            o_fwd = FWD_MEM;
        end else if (i_reg_write_w && (i_rd_w != 5'd0) && (i_rd_w == i_rs)) begin
            o_fwd = FWD_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Pipeline hazard controller: forwarding, load-use stall, branch
//            flush and data-memory wait/timeout handling.
//            Optional stall-cycle counter enabled by HAZARD_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    hazard_ctrl_if.slave bus
);

    localparam logic [1:0] c_ST_RUN      = ST_RUN;
    localparam logic [1:0] c_ST_MEM_WAIT = ST_MEM_WAIT;
    localparam logic [1:0] c_ST_ERR      = ST_ERR;

    localparam int                    c_WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [c_WAIT_W-1:0]   c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_mem_err;

    logic       w_lw_stall;
    logic       w_mem_miss;
    logic       w_hold;
    logic       w_lw_hold;
    logic       w_flush_d;
    logic       w_flush_e;
    logic       w_stall_f;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    forward_unit u_fwd_a (
        .i_rs          (bus.Rs1E),
        .i_rd_m        (bus.RdM),
        .i_rd_w        (bus.RdW),
        .i_reg_write_m (bus.RegWriteM),
        .i_reg_write_w (bus.RegWriteW),
        .o_fwd         (w_fwd_a)
    );

    forward_unit u_fwd_b (
        .i_rs          (bus.Rs2E),
        .i_rd_m        (bus.RdM),
        .i_rd_w        (bus.RdW),
        .i_reg_write_m (bus.RegWriteM),
        .i_reg_write_w (bus.RegWriteW),
        .o_fwd         (w_fwd_b)
    );

    assign w_lw_stall = bus.ResultSrcE[0] && (bus.RdE != 5'd0) &&
                        ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));
    assign w_mem_miss = bus.mem_req && !bus.mem_ready;

    // A memory stall freezes E, so it also overrides any D/E flush request.
    always_comb begin
        w_hold    = 1'b0;
        w_lw_hold = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                if (w_mem_miss) begin
                    w_hold = 1'b1;
                end else if (bus.PCSrcE) begin
                    w_flush_d = 1'b1;
                    w_flush_e = 1'b1;
                end else if (w_lw_stall) begin
                    w_lw_hold = 1'b1;
                    w_flush_e = 1'b1;
                end
            end
            c_ST_MEM_WAIT: w_hold = !bus.mem_ready;
            default:       w_hold = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_RUN:      if (w_mem_miss) w_state_nxt = c_ST_MEM_WAIT;
            c_ST_MEM_WAIT: begin
                if (bus.mem_ready)                w_state_nxt = c_ST_RUN;
                else if (r_wait_cnt == c_WAIT_LAST) w_state_nxt = c_ST_ERR;
            end
            c_ST_ERR:      w_state_nxt = c_ST_ERR;
            default:       w_state_nxt = c_ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= (r_state == c_ST_MEM_WAIT) ? r_wait_cnt + c_WAIT_W'(1) : '0;
            if (w_state_nxt == c_ST_ERR) r_mem_err <= 1'b1;
        end
    end

    assign w_stall_f = w_hold | w_lw_hold;

    // Outputs are gated by rst_n so they drop the instant reset asserts.
    assign bus.StallF    = rst_n & w_stall_f;
    assign bus.StallD    = rst_n & w_stall_f;
    assign bus.StallE    = rst_n & w_hold;
    assign bus.StallM    = rst_n & w_hold;
    assign bus.FlushW    = rst_n & w_hold;
    assign bus.FlushD    = rst_n & w_flush_d;
    assign bus.FlushE    = rst_n & w_flush_e;
    assign bus.ForwardAE = rst_n ? w_fwd_a : FWD_NONE;
    assign bus.ForwardBE = rst_n ? w_fwd_b : FWD_NONE;
    assign bus.mem_err   = r_mem_err;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall_f && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
        end
    end

    assign bus.stall_cycles = r_stall_cnt;
`else
    assign bus.stall_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Self-checking bench for hazard_ctrl: directed literal cases plus
//            randomized traffic compared each cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int MT      = 4;
    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_WIDTH(CW)) bus ();

    hazard_ctrl #(
        .MEM_TIMEOUT (MT),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_waited: cycles already spent waiting on the outstanding access (0 = none)
    bit m_err    = 1'b0;
    int m_waited = 0;
    int m_cnt    = 0;

    function automatic logic [1:0] fwd_of(input logic [4:0] rs);
        if (bus.RegWriteM && bus.RdM != 5'd0 && bus.RdM == rs) return FWD_MEM;
        if (bus.RegWriteW && bus.RdW != 5'd0 && bus.RdW == rs) return FWD_WB;
        return FWD_NONE;
    endfunction

    task automatic model_outs(output logic sf, output logic sd, output logic se,
                              output logic sm, output logic fd, output logic fe,
                              output logic fw);
        logic lw;
        logic hold;
        {sf, sd, se, sm, fd, fe, fw} = 7'b0;
        lw = bus.ResultSrcE[0] && bus.RdE != 5'd0 &&
             (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
        hold = m_err || (m_waited > 0 && !bus.mem_ready) ||
               (m_waited == 0 && bus.mem_req && !bus.mem_ready);
        if (rst_n) begin
            if (hold) begin
                {sf, sd, se, sm, fw} = 5'b11111;
            end else if (m_waited == 0) begin
                if (bus.PCSrcE) begin
                    fd = 1'b1;
                    fe = 1'b1;
                end else if (lw) begin
                    sf = 1'b1;
                    sd = 1'b1;
                    fe = 1'b1;
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        logic sf, sd, se, sm, fd, fe, fw;
        if (!rst_n) begin
            m_err    = 1'b0;
            m_waited = 0;
            m_cnt    = 0;
        end else begin
            model_outs(sf, sd, se, sm, fd, fe, fw);
            if (sf && m_cnt < CNT_MAX) m_cnt++;
            if (!m_err) begin
                if (m_waited > 0) begin
                    if (bus.mem_ready)      m_waited = 0;
                    else if (m_waited == MT) m_err = 1'b1;
                    else                     m_waited++;
                end else if (bus.mem_req && !bus.mem_ready) begin
                    m_waited = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic sf, sd, se, sm, fd, fe, fw;
        model_outs(sf, sd, se, sm, fd, fe, fw);
        chk("StallF", bus.StallF, sf);
        chk("StallD", bus.StallD, sd);
        chk("StallE", bus.StallE, se);
        chk("StallM", bus.StallM, sm);
        chk("FlushD", bus.FlushD, fd);
        chk("FlushE", bus.FlushE, fe);
        chk("FlushW", bus.FlushW, fw);
        chk("ForwardAE", bus.ForwardAE, rst_n ? fwd_of(bus.Rs1E) : 2'b00);
        chk("ForwardBE", bus.ForwardBE, rst_n ? fwd_of(bus.Rs2E) : 2'b00);
        chk("mem_err", bus.mem_err, m_err);
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cycles", bus.stall_cycles, m_cnt);
`else
        chk("stall_cycles", bus.stall_cycles, 0);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic clr_inputs();
        bus.Rs1D = '0; bus.Rs2D = '0; bus.Rs1E = '0; bus.Rs2E = '0; bus.RdE = '0;
        bus.ResultSrcE = '0; bus.PCSrcE = 1'b0; bus.RdM = '0; bus.RdW = '0;
        bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0;
        bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int slow;
        clr_inputs();
        rst_n = 1'b0;
        bus.RdM = 5'd5; bus.RegWriteM = 1'b1; bus.Rs1E = 5'd5;
        @(negedge clk);
        chk("rst_fwdA", bus.ForwardAE, 2'b00);
        chk("rst_stallF", bus.StallF, 0);
        chk("rst_mem_err", bus.mem_err, 0);
        chk("rst_stall_cycles", bus.stall_cycles, 0);

        // forwarding priority
        next(); rst_n = 1'b1;
        bus.RdW = 5'd5; bus.RegWriteW = 1'b1;
        @(negedge clk); chk("fwd_mem", bus.ForwardAE, 2'b10);
        next(); bus.RdM = 5'd0;
        @(negedge clk); chk("fwd_wb", bus.ForwardAE, 2'b01);
        next(); bus.Rs1E = 5'd0; bus.Rs2E = 5'd5; bus.RdM = 5'd5; bus.RegWriteM = 1'b0;
        @(negedge clk);
        chk("fwdB_wb", bus.ForwardBE, 2'b01);
        chk("fwdA_none", bus.ForwardAE, 2'b00);

        // load-use stall
        next(); clr_inputs(); bus.ResultSrcE = 2'b01; bus.RdE = 5'd7; bus.Rs2D = 5'd7;
        @(negedge clk);
        chk("lw_stallF", bus.StallF, 1);
        chk("lw_stallD", bus.StallD, 1);
        chk("lw_flushE", bus.FlushE, 1);
        chk("lw_flushD", bus.FlushD, 0);
        next(); clr_inputs();
        @(negedge clk); chk("lw_release", bus.StallF, 0);
        next(); bus.ResultSrcE = 2'b01; bus.RdE = 5'd0; bus.Rs2D = 5'd7;
        @(negedge clk); chk("lw_rd0", bus.StallF, 0);

        // branch beats load-use
        next(); bus.RdE = 5'd7; bus.Rs1D = 5'd7; bus.PCSrcE = 1'b1;
        @(negedge clk);
        chk("br_flushD", bus.FlushD, 1);
        chk("br_flushE", bus.FlushE, 1);
        chk("br_stallF", bus.StallF, 0);
        chk("br_stallD", bus.StallD, 0);

        // three-cycle memory wait
        next(); clr_inputs(); rst_n = 1'b0;
        next(); rst_n = 1'b1; bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mw_stallF", bus.StallF, 1);
            chk("mw_stallM", bus.StallM, 1);
            chk("mw_flushW", bus.FlushW, 1);
            if (i < 2) next();
        end
        next(); bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("mw_rel_stallF", bus.StallF, 0);
        chk("mw_rel_stallE", bus.StallE, 0);
        chk("mw_rel_flushW", bus.FlushW, 0);
        next(); clr_inputs();
        @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
        chk("mw_stall_cycles", bus.stall_cycles, 3);
`else
        chk("mw_stall_cycles", bus.stall_cycles, 0);
`endif

        // timeout into ERR, then saturate the counter
        next(); rst_n = 1'b0;
        next(); rst_n = 1'b1; bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 4) chk("to_err_pre", bus.mem_err, 0);
            if (k == 5) begin
                chk("to_err_set", bus.mem_err, 1);
                chk("to_err_stallM", bus.StallM, 1);
            end
            next();
        end
        for (int k = 0; k < 300; k++) begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            bus.PCSrcE    = 1'($urandom_range(0, 1));
            next();
        end
        @(negedge clk);
        chk("err_sticky", bus.mem_err, 1);
        chk("err_stallF", bus.StallF, 1);
`ifdef HAZARD_PERF_CNT_EN
        chk("cnt_saturate", bus.stall_cycles, 8'hFF);
`else
        chk("cnt_saturate", bus.stall_cycles, 0);
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("err_rst_stallF", bus.StallF, 0);
        chk("err_rst_flushW", bus.FlushW, 0);
        chk("err_rst_mem_err", bus.mem_err, 0);
        next(); rst_n = 1'b1; clr_inputs();
        @(negedge clk);
        chk("err_rst_run", bus.StallF, 0);
        chk("err_rst_run_err", bus.mem_err, 0);

        // async reset during MEM_WAIT
        next(); bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
        bus.RdM = 5'd5; bus.RegWriteM = 1'b1; bus.Rs1E = 5'd5;
        next();
        #2 rst_n = 1'b0;
        #1;
        chk("mw_rst_stallF", bus.StallF, 0);
        chk("mw_rst_stallM", bus.StallM, 0);
        chk("mw_rst_flushW", bus.FlushW, 0);
        chk("mw_rst_fwdA", bus.ForwardAE, 2'b00);
        next(); rst_n = 1'b1; clr_inputs();
        @(negedge clk);
        chk("mw_rst_residual", bus.StallF, 0);

        // randomized traffic
        slow = 0;
        for (int n = 0; n < 3000; n++) begin
            next();
            if ((n % 128) == 0) slow = int'($urandom_range(0, 1));
            rst_n = m_err ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 199) != 0);
            bus.Rs1D       = 5'($urandom_range(0, 3));
            bus.Rs2D       = 5'($urandom_range(0, 3));
            bus.Rs1E       = 5'($urandom_range(0, 3));
            bus.Rs2E       = 5'($urandom_range(0, 3));
            bus.RdE        = 5'($urandom_range(0, 3));
            bus.RdM        = 5'($urandom_range(0, 3));
            bus.RdW        = 5'($urandom_range(0, 3));
            bus.ResultSrcE = 2'($urandom_range(0, 3));
            bus.PCSrcE     = ($urandom_range(0, 7) == 0);
            bus.RegWriteM  = 1'($urandom_range(0, 1));
            bus.RegWriteW  = 1'($urandom_range(0, 1));
            bus.mem_req    = ($urandom_range(0, 2) == 0);
            bus.mem_ready  = (slow != 0) ? ($urandom_range(0, 15) == 0)
                                         : ($urandom_range(0, 2) != 0);
        end
        next(); rst_n = 1'b1; clr_inputs();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, max cycles waiting on mem_ready before error.
REQ-002 Parameter CNT_WIDTH, default 32, width of stall_cycles counter.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 Rs1D, Rs2D  in  5 each  source registers in Decode.
REQ-006 Rs1E, Rs2E, RdE  in  5 each  source and destination registers in Execute.
REQ-007 ResultSrcE  in  2  Execute result select; bit0=1 marks a load.
REQ-008 PCSrcE  in  1  taken branch or jump in Execute.
REQ-009 RdM, RdW  in  5 each  destinations in Memory and Writeback.
REQ-010 RegWriteM, RegWriteW  in  1 each  register-write enables in M and W.
REQ-011 mem_req  in  1  data-memory access active in M; mem_ready  in  1  access completes this cycle.
REQ-012 StallF, StallD, StallE, StallM  out  1 each  hold the corresponding pipeline register.
REQ-013 FlushD, FlushE, FlushW  out  1 each  load a bubble into the D, E and MW registers; FlushW clears RegWriteW.
REQ-014 ForwardAE, ForwardBE  out  2 each  operand forward select.
REQ-015 mem_err  out  1  sticky memory-timeout flag.
REQ-016 stall_cycles  out  CNT_WIDTH  count of stalled cycles.

Function
REQ-017 Forward select SHALL be 2'b10 when RegWriteM, RdM!=0 and RdM==Rs1E (or Rs2E); else 2'b01 on the same test with W; else 2'b00; M wins over W.
REQ-018 lwStall SHALL be ResultSrcE[0] && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
REQ-019 In RUN, lwStall SHALL assert StallF, StallD and FlushE for exactly that cycle; the one-bubble load-use penalty follows from this.
REQ-020 In RUN, PCSrcE SHALL assert FlushD and FlushE; if lwStall is also high, PCSrcE wins and StallF/StallD stay low.
REQ-021 FSM states SHALL be RUN, MEM_WAIT and ERR.
REQ-022 RUN -> MEM_WAIT SHALL occur when mem_req && !mem_ready; if mem_req && mem_ready, the FSM stays in RUN with no stall.
REQ-023 In RUN with mem_req && !mem_ready, StallF/D/E/M and FlushW SHALL assert combinationally that same cycle.
REQ-024 In MEM_WAIT, StallF/D/E/M and FlushW SHALL assert every cycle; FlushD/FlushE SHALL be suppressed; PCSrcE and lwStall SHALL be ignored.
REQ-025 MEM_WAIT -> RUN SHALL occur on the edge where mem_ready=1; stalls SHALL release combinationally in the mem_ready cycle.
REQ-026 A wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle.
REQ-027 MEM_WAIT -> ERR SHALL occur when the wait counter reaches MEM_TIMEOUT-1 without mem_ready; mem_ready in that same cycle SHALL win and go to RUN.
REQ-028 ERR SHALL set mem_err, assert all four stalls and FlushW, and remain until reset.
REQ-029 Forwarding outputs SHALL stay functional in every state.

Reset
REQ-030 rst_n low SHALL immediately force state RUN, wait counter 0, mem_err 0 and stall_cycles 0.
REQ-031 While rst_n is low, all stall and flush outputs SHALL be 0 and ForwardAE/BE 2'b00.
REQ-032 Reset asserted mid-MEM_WAIT or in ERR SHALL abandon the wait with no residual stall after release.

Configuration
REQ-033 With HAZARD_PERF_CNT_EN defined, stall_cycles SHALL increment once per cycle in which StallF=1, saturating at all-ones.
REQ-034 Without HAZARD_PERF_CNT_EN, stall_cycles SHALL be tied to 0 and no counter logic SHALL be synthesized.

Structure
REQ-035 Package hazard_pkg SHALL hold the FSM state enum and the constants FWD_NONE=2'b00, FWD_WB=2'b01 and FWD_MEM=2'b10.
REQ-036 The per-operand forwarding compare SHALL be sub-module forward_unit, instantiated twice.

Verification
REQ-037 Inputs RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=2'b10; with RdM=0 instead -> ForwardAE=2'b01.
REQ-038 Inputs ResultSrcE=2'b01, RdE=7, Rs2D=7 for 1 cycle -> StallF=StallD=FlushE=1 for 1 cycle; with RdE=0 instead -> no stall.
REQ-039 Inputs PCSrcE=1 together with a lwStall condition -> FlushD=FlushE=1 and StallF=StallD=0.
REQ-040 mem_req=1 with mem_ready low for 3 cycles, then high -> StallF/D/E/M and FlushW high for 3 cycles, low on the 4th; stall_cycles=3 with the macro defined.
REQ-041 mem_req=1 with mem_ready never asserted, MEM_TIMEOUT=4 -> mem_err=1 after 4 cycles with stalls held; rst_n pulse -> mem_err=0 and state RUN.
REQ-042 rst_n asserted during MEM_WAIT -> all outputs 0 asynchronously, before the next clk edge.
